// File: rtl/rtc_pkg.sv
// Shared mode encoding, BCD limits and the BCD increment helper for the RTC.
package rtc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } rtc_state_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  // Two-digit BCD increment that wraps to 00 once the limit is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v == lim) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchronizer, 1 kHz-sampled debounce, one-cycle press pulse.
module btn_debounce
  import rtc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_1k_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   level_prev_q;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_1k_i) begin
      if (sync_q[LAST] != level_q) begin
        if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
          level_d = sync_q[LAST];
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= btn_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/rtc_timekeeper.sv
// HH:MM:SS BCD timekeeper driven by sampled 1 Hz / 1 kHz strobes, with a
// two-button RUN / SET_HOUR / SET_MIN mode machine.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_25M,
  input  logic       reset,
  input  logic       clk_1s,
  input  logic       clk_1k,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] set_mode,
  output logic       sec_tick,
  output logic       blink
);

  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] s1s_q, s1k_q;
  logic                   s1s_prev_q, s1k_prev_q;
  logic                   s1s_valid_q, s1s_armed_q;
  logic                   tick_1k;
  logic                   mode_press, up_press;

  rtc_state_e state_q, state_d;
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;

  always_ff @(posedge clk_25M or posedge reset) begin
    if (reset) begin
      s1s_q       <= '0;
      s1k_q       <= '0;
      s1s_prev_q  <= 1'b0;
      s1k_prev_q  <= 1'b0;
      s1s_valid_q <= 1'b0;
      s1s_armed_q <= 1'b0;
    end else begin
      s1s_q[0] <= clk_1s;
      s1k_q[0] <= clk_1k;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        s1s_q[i] <= s1s_q[i-1];
        s1k_q[i] <= s1k_q[i-1];
      end
      s1s_prev_q  <= s1s_q[LAST];
      s1k_prev_q  <= s1k_q[LAST];
      s1s_valid_q <= 1'b1;
      // A real low sample of clk_1s must be seen after reset before any tick,
      // so a clk_1s held high across reset release does not count as an edge.
      if (s1s_valid_q && !s1s_q[0]) begin
        s1s_armed_q <= 1'b1;
      end
    end
  end

  assign tick_1k  = s1k_q[LAST] & ~s1k_prev_q;
  assign sec_tick = s1s_q[LAST] & ~s1s_prev_q & s1s_armed_q;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)) u_mode (
    .clk_i     (clk_25M),
    .rst_i     (reset),
    .tick_1k_i (tick_1k),
    .btn_i     (btn_mode),
    .press_o   (mode_press)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)) u_up (
    .clk_i     (clk_25M),
    .rst_i     (reset),
    .tick_1k_i (tick_1k),
    .btn_i     (btn_up),
    .press_o   (up_press)
  );

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    case (state_q)
      RUN: begin
        if (sec_tick) begin
          sec_d = bcd_inc(sec_q, MIN_MAX);
          if (sec_q == MIN_MAX) begin
            min_d = bcd_inc(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
              hour_d = bcd_inc(hour_q, HOUR_MAX);
            end
          end
        end
        if (mode_press) begin
          state_d = SET_HOUR;
        end
      end
      SET_HOUR: begin
        if (mode_press) begin
          state_d = SET_MIN;
        end else if (up_press) begin
          hour_d = bcd_inc(hour_q, HOUR_MAX);
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          state_d = RUN;
          sec_d   = '0;
        end else if (up_press) begin
          min_d = bcd_inc(min_q, MIN_MAX);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_25M or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign hour_bcd = hour_q;
  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign set_mode = state_q;
  assign blink    = (state_q != RUN) & s1s_q[LAST];

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized bench for rtc_timekeeper against an integer hh/mm/ss + mode model.
module tb_rtc_timekeeper;

  logic       clk_25M = 1'b0;
  logic       reset, clk_1s, clk_1k, btn_mode, btn_up;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] set_mode;
  logic       sec_tick, blink;

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  int hh, mm, ss, md;  // md: 0 RUN, 1 SET_HOUR, 2 SET_MIN

  always #20 clk_25M = ~clk_25M;

  rtc_timekeeper #(.DEBOUNCE_MS(20), .SYNC_STAGES(2)) dut (
    .clk_25M  (clk_25M),
    .reset    (reset),
    .clk_1s   (clk_1s),
    .clk_1k   (clk_1k),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .set_mode (set_mode),
    .sec_tick (sec_tick),
    .blink    (blink)
  );

  always @(negedge clk_25M) if (sec_tick === 1'b1) ticks++;

  initial begin
    #(100_000 * 40);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".hour"}, hour_bcd, to_bcd(hh));
    check({tag, ".min"},  min_bcd,  to_bcd(mm));
    check({tag, ".sec"},  sec_bcd,  to_bcd(ss));
    check({tag, ".mode"}, set_mode, md);
  endtask

  function automatic void model_second();
    if (md == 0) begin
      ss++;
      if (ss == 60) begin
        ss = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          hh = (hh + 1) % 24;
        end
      end
    end
  endfunction

  // n periods of the 1 kHz strobe, 6 system clocks each
  task automatic ms(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      clk_1k = 1'b1;
      repeat (3) @(negedge clk_25M);
      clk_1k = 1'b0;
      repeat (3) @(negedge clk_25M);
    end
  endtask

  // nb bounce segments (seg ms each, 0 = random 1..4), then a clean 25 ms hold and release
  task automatic press(input bit m, input bit u, input int unsigned nb, input int unsigned seg);
    for (int unsigned i = 0; i < nb; i++) begin
      btn_mode = m & (i % 2 == 0);
      btn_up   = u & (i % 2 == 0);
      ms(seg != 0 ? seg : $urandom_range(1, 4));
    end
    btn_mode = m;
    btn_up   = u;
    ms(25);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    ms(25);
    if (m) begin
      if (md == 2) ss = 0;
      md = (md + 1) % 3;
    end else if (u) begin
      if (md == 1) hh = (hh + 1) % 24;
      else if (md == 2) mm = (mm + 1) % 60;
    end
  endtask

  task automatic sec_pulse(input int n);
    int t0;
    for (int i = 0; i < n; i++) begin
      t0 = ticks;
      clk_1s = 1'b1;
      repeat (5) @(negedge clk_25M);
      check("blink", blink, (md != 0) ? 1 : 0);
      clk_1s = 1'b0;
      repeat (5) @(negedge clk_25M);
      check("tick_once", ticks - t0, 1);
      model_second();
    end
  endtask

  initial begin
    int t0;
    int r;
    reset = 1'b1; clk_1s = 1'b0; clk_1k = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    hh = 0; mm = 0; ss = 0; md = 0;
    repeat (5) @(negedge clk_25M);
    check_all("reset_held");
    check("reset.tick", sec_tick, 0);
    check("reset.blink", blink, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk_25M);
    check_all("post_reset");

    // tick latency: rises at negedge k, pulse visible only at negedge k+2
    t0 = ticks;
    clk_1s = 1'b1;
    @(negedge clk_25M); check("lat.e1", sec_tick, 0);
    @(negedge clk_25M); check("lat.e2", sec_tick, 1);
    @(negedge clk_25M); check("lat.e3", sec_tick, 0);
    check("lat.sec", sec_bcd, 8'h01);
    repeat (3) @(negedge clk_25M);
    clk_1s = 1'b0;
    repeat (5) @(negedge clk_25M);
    model_second();
    sec_pulse(59);
    check_all("sixty_sec");
    check("sixty_ticks", ticks - t0, 60);

    // set hour: 9 clean presses, a bouncy one, then up to 23
    press(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) press(0, 1, 0, 0);
    check_all("hour09");
    press(0, 1, 5, 3);
    check_all("bounce_hour10");
    for (int i = 0; i < 13; i++) press(0, 1, 0, 0);
    check_all("hour23");
    sec_pulse(3);
    check_all("frozen_in_set");
    press(0, 1, 0, 0);
    check_all("hour_wrap");
    for (int i = 0; i < 23; i++) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    for (int i = 0; i < 58; i++) press(0, 1, 0, 0);
    check_all("min59");
    press(1, 0, 0, 0);
    check_all("run_2359");
    sec_pulse(59);
    check_all("t235959");
    sec_pulse(1);
    check_all("midnight");

    // mode press accepted in the same cycle as a sec_tick in RUN
    t0 = ticks;
    btn_mode = 1'b1;
    ms(19);
    clk_1k = 1'b1;
    @(negedge clk_25M);
    clk_1s = 1'b1;
    repeat (2) @(negedge clk_25M);
    clk_1k = 1'b0;
    repeat (3) @(negedge clk_25M);
    btn_mode = 1'b0;
    ms(25);
    clk_1s = 1'b0;
    repeat (5) @(negedge clk_25M);
    ss = 1; md = 1;
    check_all("tick_and_mode");
    check("tick_and_mode.ticks", ticks - t0, 1);

    // simultaneous mode + up in SET_HOUR at 05
    for (int i = 0; i < 5; i++) press(0, 1, 0, 0);
    check_all("hour05");
    press(1, 1, 0, 0);
    check_all("mode_beats_up");
    press(1, 0, 0, 0);
    check_all("sec_cleared");

    // reach 12:34 in SET_MIN, then reset with a half-debounced mode press pending
    press(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    for (int i = 0; i < 34; i++) press(0, 1, 0, 0);
    check_all("t1234");
    btn_mode = 1'b1;
    clk_1s = 1'b1;
    ms(15);
    check("pre_reset.blink", blink, 1);
    check_all("pre_reset");
    #5 reset = 1'b1;
    #1;
    hh = 0; mm = 0; ss = 0; md = 0;
    check_all("async_reset");
    check("async_reset.tick", sec_tick, 0);
    check("async_reset.blink", blink, 0);
    repeat (4) @(negedge clk_25M);
    reset = 1'b0;
    t0 = ticks;
    ms(8);
    btn_mode = 1'b0;
    ms(25);
    check_all("pending_discarded");
    check("no_tick_held_high", ticks - t0, 0);
    clk_1s = 1'b0;
    repeat (5) @(negedge clk_25M);
    sec_pulse(1);
    check_all("fresh_edge");

    // random operation mix
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 3);
      if (r == 0) press(1, 0, $urandom_range(0, 4), 0);
      else if (r == 3) sec_pulse($urandom_range(1, 4));
      else press(0, 1, $urandom_range(0, 4), 0);
      check_all("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
